output_accuracy_tracker: RTL
============================

Name: output_accuracy_tracker

Overview:
- Sits directly downstream of the DNN top and consumes its outputs.
- Each block cycle, the DNN emits `actL_alln`, a one-hot prediction over all output neurons, and streams the ideal answer `ansL` at `zbyfi` bits per clock.
- This block reassembles the full ideal-answer vector and compares it to the prediction once per block cycle.
- It reports a per-sample hit strobe and a windowed correct-count used for on-chip training accuracy monitoring.

Parameters:
- n_out, 16, number of output neurons (n[L-1]).
- zbyfi, 1, ideal-answer bits delivered per clock (z[L-2]/fi[L-2]); n_out/zbyfi must equal cpc-2.
- cpc, 18, clocks per block cycle.
- L, 3, total layers; sets warm-up length in block cycles.
- window, 1024, samples per accuracy window (power of 2 not required, ≥2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high; clears all state.
- cycle_index  input  $clog2(cpc)  current clock index within block cycle, from cycle_block_counter.
- en  input  1  sample stream valid; samples completing while en=0 are discarded.
- ansL  input  zbyfi  ideal-answer chunk for the current clock.
- actL_alln  input  n_out  one-hot predicted class, updated by the DNN at cycle_index==cpc-1.
- hit  output  1  one-clock strobe: sample scored and correct.
- scored  output  1  one-clock strobe: sample scored (correct or not).
- ans_err  output  1  one-clock strobe: assembled ideal answer not one-hot.
- correct_count  output  $clog2(window+1)  running correct count in the current window.
- window_correct  output  $clog2(window+1)  correct count of the last completed window.
- window_done  output  1  one-clock strobe when window_correct updates.

Behaviour:
- Reset (async, active-high): every output is 0. Clears the assembly register, ready flag and warm-up counter. Reset asserted mid-window discards the partial window; window_correct returns to 0.
- Assembly:
  - At a clock with cycle_index==k+2, for k = 0..n_out/zbyfi-1, write ansL into bits [k*zbyfi +: zbyfi] of ans_acc.
  - cycle_index 0 and 1 are ignored.
- Transfer: at cycle_index==cpc-1, copy ans_acc (including the chunk written that same clock) into ans_done. Set ready=1 if warm-up is complete and en=1; otherwise ready=0.
- Warm-up:
  - A counter increments at each cycle_index==cpc-1 and saturates at L.
  - Warm-up is complete when the count equals L.
  - The first L block cycles after reset are never scored.
- Scoring, at the clock where cycle_index==0 and ready=1:
  - scored=1.
  - hit=1 iff (ans_done & actL_alln) != 0 and ans_done is one-hot.
  - ans_err=1 iff ans_done is not exactly one-hot; this covers all-zero and multi-bit. ans_err forces hit=0.
  - ready clears the same clock.
  - Latency: last ansL chunk to hit/scored is 2 clocks; the strobes are registered.
- Window counting:
  - A sample counter, width $clog2(window), increments on each scored.
  - correct_count increments on each hit.
  - When a scored sample is the window-th one:
    - window_correct <= correct_count + hit (that sample included).
    - correct_count <= 0 and the sample counter <= 0.
    - window_done=1 for one clock, coincident with scored.
  - correct_count never exceeds window; no wrap can occur.
- Simultaneous events:
  - en deasserting during assembly affects only the ready decision at cpc-1.
  - A warm-up completion clock and a transfer clock coincide by design; that transfer is the first eligible one.
- Width rules: all comparisons are bitwise. One-hot test is popcount==1, realised as v!=0 && (v&(v-1))==0. No arithmetic on data bits.

Decomposition:
- Shared package (dnn_pkg): function clog2_safe(x), returning 1 for x≤1, for port widths; localparam-derived CHUNKS = n_out/zbyfi.
- One sub-module: ans_collector. It holds ans_acc/ans_done and the transfer logic, with inputs clk, reset, cycle_index, ansL and outputs ans_done plus a done pulse.
- Scoring, warm-up and window logic stay in the top.

Test Plan:
- Reset mid-window: assert reset after 5 hits → all outputs 0 within the same clock; the next window restarts with warm-up of L=3 block cycles and no scored strobe.
- Correct sample after warm-up: ansL=1 only at cycle_index 7 (class 5); actL_alln=16'h0020 → scored=1, hit=1 at the next cycle_index 0; correct_count=1.
- Wrong sample: ansL targets class 5; actL_alln=16'h0001 → scored=1, hit=0; correct_count unchanged.
- Window rollover: window=4, hits pattern 1,0,1,1 → window_done=1 on the 4th scored; window_correct=3; correct_count=0 on the same clock.
- Bad answer: ansL high at cycle_index 2 and 3 (two classes set); actL_alln=16'h0001 → ans_err=1, hit=0, scored=1.
- en gating: en=0 at cycle_index==cpc-1 for one block cycle → no scored that block cycle; the sample counter and correct_count hold.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared constants and helpers for the DNN output-side blocks.
package dnn_pkg;

  localparam int N_OUT_DEF  = 16;
  localparam int ZBYFI_DEF  = 1;
  localparam int CPC_DEF    = 18;
  localparam int L_DEF      = 3;
  localparam int WINDOW_DEF = 1024;

  // Ideal-answer chunks per block cycle for the default configuration.
  localparam int CHUNKS = N_OUT_DEF / ZBYFI_DEF;

  // $clog2 that never yields a zero-width vector.
  function automatic int clog2_safe(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/ans_collector.sv
// Reassembles the streamed ideal answer and latches it once per block cycle.
module ans_collector
  import dnn_pkg::*;
#(
  parameter int n_out = 16,
  parameter int zbyfi = 1,
  parameter int cpc   = 18
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [clog2_safe(cpc)-1:0]    cycle_index,
  input  logic [zbyfi-1:0]              ansL,
  output logic [n_out-1:0]              ans_done,
  output logic                          done
);

  localparam int NCH = n_out / zbyfi;
  localparam int CIW = clog2_safe(cpc);

  logic [n_out-1:0] ans_acc_q, ans_acc_d;
  logic [n_out-1:0] ans_done_q;

  // Transfer happens on the last clock of the block cycle.
  assign done     = (cycle_index == CIW'(cpc - 1));
  assign ans_done = ans_done_q;

  // Merge this clock's chunk; clocks 0 and 1 carry no answer data.
  always_comb begin
    ans_acc_d = ans_acc_q;
    for (int k = 0; k < NCH; k++) begin
      if (cycle_index == CIW'(k + 2))
        ans_acc_d[k*zbyfi +: zbyfi] = ansL;
    end
  end

  // Accumulator and completed-answer registers; transfer includes the same-clock chunk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ans_acc_q  <= '0;
      ans_done_q <= '0;
    end else begin
      ans_acc_q <= ans_acc_d;
      if (done) ans_done_q <= ans_acc_d;
    end
  end

endmodule

// File: rtl/output_accuracy_tracker.sv
// Scores each DNN prediction against the reassembled ideal answer and keeps windowed accuracy.
module output_accuracy_tracker
  import dnn_pkg::*;
#(
  parameter int n_out  = 16,
  parameter int zbyfi  = 1,
  parameter int cpc    = 18,
  parameter int L      = 3,
  parameter int window = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [clog2_safe(cpc)-1:0]          cycle_index,
  input  logic                                en,
  input  logic [zbyfi-1:0]                    ansL,
  input  logic [n_out-1:0]                    actL_alln,
  output logic                                hit,
  output logic                                scored,
  output logic                                ans_err,
  output logic [clog2_safe(window+1)-1:0]     correct_count,
  output logic [clog2_safe(window+1)-1:0]     window_correct,
  output logic                                window_done
);

  localparam int CIW = clog2_safe(cpc);
  localparam int CCW = clog2_safe(window + 1);
  localparam int SCW = clog2_safe(window);
  localparam int WUW = clog2_safe(L + 1);
  localparam logic [n_out-1:0] ONE = n_out'(1);

  logic [n_out-1:0] ans_done;
  logic             xfer;

  ans_collector #(.n_out(n_out), .zbyfi(zbyfi), .cpc(cpc)) u_collect (
    .clk         (clk),
    .reset       (reset),
    .cycle_index (cycle_index),
    .ansL        (ansL),
    .ans_done    (ans_done),
    .done        (xfer)
  );

  logic           hit_q, hit_d, scored_q, scored_d, err_q, err_d, wdone_q, wdone_d;
  logic           ready_q, ready_d;
  logic [CCW-1:0] cc_q, cc_d, wc_q, wc_d;
  logic [SCW-1:0] samp_q, samp_d;
  logic [WUW-1:0] warm_q, warm_d, warm_inc;
  logic           onehot, score;

  assign onehot = (ans_done != '0) && ((ans_done & (ans_done - ONE)) == '0);
  assign score  = ready_q && (cycle_index == '0);
  assign warm_inc = (warm_q == WUW'(L)) ? warm_q : warm_q + WUW'(1);

  assign hit            = hit_q;
  assign scored         = scored_q;
  assign ans_err        = err_q;
  assign window_done    = wdone_q;
  assign correct_count  = cc_q;
  assign window_correct = wc_q;

  // Warm-up/ready decision at transfer, scoring and window accounting at clock 0.
  always_comb begin
    warm_d   = warm_q;
    ready_d  = ready_q;
    cc_d     = cc_q;
    wc_d     = wc_q;
    samp_d   = samp_q;
    hit_d    = 1'b0;
    scored_d = 1'b0;
    err_d    = 1'b0;
    wdone_d  = 1'b0;
    if (xfer) begin
      warm_d  = warm_inc;
      // The transfer that completes warm-up is already eligible.
      ready_d = en && (warm_inc == WUW'(L));
    end
    if (score) begin
      ready_d  = 1'b0;
      scored_d = 1'b1;
      err_d    = !onehot;
      hit_d    = onehot && ((ans_done & actL_alln) != '0);
      if (samp_q == SCW'(window - 1)) begin
        wc_d    = cc_q + CCW'(hit_d);
        cc_d    = '0;
        samp_d  = '0;
        wdone_d = 1'b1;
      end else begin
        cc_d   = cc_q + CCW'(hit_d);
        samp_d = samp_q + SCW'(1);
      end
    end
  end

  // State and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q   <= '0;
      ready_q  <= 1'b0;
      cc_q     <= '0;
      wc_q     <= '0;
      samp_q   <= '0;
      hit_q    <= 1'b0;
      scored_q <= 1'b0;
      err_q    <= 1'b0;
      wdone_q  <= 1'b0;
    end else begin
      warm_q   <= warm_d;
      ready_q  <= ready_d;
      cc_q     <= cc_d;
      wc_q     <= wc_d;
      samp_q   <= samp_d;
      hit_q    <= hit_d;
      scored_q <= scored_d;
      err_q    <= err_d;
      wdone_q  <= wdone_d;
    end
  end

endmodule
